// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: tracks producers in E/M/W, raises stall for
// unresolved RAW and busy-MDU hazards, and picks forwarding sources for D, E and M.
module hazard_ctrl #(
    parameter int MULT_CYC = 5,
    parameter int DIV_CYC  = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] rs_D,
    input  logic [4:0] rt_D,
    input  logic [1:0] tuse_rs,
    input  logic [1:0] tuse_rt,
    input  logic [4:0] a3_D,
    input  logic [1:0] cls_D,
    input  logic       md_start_D,
    input  logic       md_div_D,
    input  logic       md_use_D,
    output logic [2:0] selRsD,
    output logic [2:0] selRtD,
    output logic [2:0] selRsE,
    output logic [2:0] selRtE,
    output logic [2:0] selRtM,
    output logic       stall
);

    localparam logic [1:0] CLS_ALU = 2'd0;
    localparam logic [1:0] CLS_MEM = 2'd1;
    localparam logic [1:0] CLS_PC8 = 2'd2;
    localparam logic [1:0] CLS_MD  = 2'd3;

    localparam logic [3:0] MULT_LD = 4'(MULT_CYC);
    localparam logic [3:0] DIV_LD  = 4'(DIV_CYC);

    typedef struct packed {
        logic [4:0] rs;
        logic [4:0] rt;
        logic [4:0] a3;
        logic [1:0] cls;
        logic [1:0] tnew;
        logic       md_start;
        logic       md_div;
    } rec_t;

    rec_t       e_q, m_q, w_q;
    rec_t       e_d, m_d, w_d;
    logic [3:0] busy_q, busy_d;
    logic [3:0] rs_chk, rt_chk;
    logic       md_stall;

    function automatic logic hit(input rec_t s, input logic [4:0] r);
        return (s.a3 != 5'd0) && (s.a3 == r);
    endfunction

    function automatic logic [1:0] tnew_init(input logic [1:0] cls);
        case (cls)
            CLS_ALU: return 2'd1;
            CLS_MEM: return 2'd2;
            default: return 2'd0;
        endcase
    endfunction

    function automatic logic [1:0] tnew_dec(input logic [1:0] t);
        return (t == 2'd0) ? 2'd0 : t - 2'd1;
    endfunction

    // Returns {stall, select} for one D operand; nearest matching stage wins.
    function automatic logic [3:0] d_fwd(input rec_t e, input rec_t m, input rec_t w,
                                         input logic [4:0] r, input logic [1:0] tuse);
        logic       found;
        logic [1:0] tnew;
        logic [2:0] sel;
        found = 1'b0;
        tnew  = 2'd0;
        sel   = 3'd0;
        if (hit(e, r)) begin
            found = 1'b1;
            tnew  = e.tnew;
            if (e.cls == CLS_PC8)     sel = 3'd1;
            else if (e.cls == CLS_MD) sel = 3'd6;
        end else if (hit(m, r)) begin
            found = 1'b1;
            tnew  = m.tnew;
            case (m.cls)
                CLS_PC8: sel = 3'd2;
                CLS_ALU: sel = 3'd3;
                CLS_MD:  sel = 3'd7;
                default: sel = 3'd0;
            endcase
        end else if (hit(w, r)) begin
            found = 1'b1;
            tnew  = w.tnew;
            sel   = (w.cls == CLS_PC8) ? 3'd4 : 3'd5;
        end
        if (tnew != 2'd0) sel = 3'd0;
        return {found && (tuse != 2'd3) && (tnew > tuse), sel};
    endfunction

    function automatic logic [2:0] e_fwd(input rec_t m, input rec_t w, input logic [4:0] r);
        logic [2:0] sel;
        sel = 3'd0;
        if (hit(m, r)) begin
            case (m.cls)
                CLS_PC8: sel = 3'd1;
                CLS_ALU: sel = 3'd2;
                CLS_MD:  sel = 3'd5;
                default: sel = 3'd0;
            endcase
        end else if (hit(w, r)) begin
            sel = (w.cls == CLS_PC8) ? 3'd3 : 3'd4;
        end
        return sel;
    endfunction

    assign rs_chk   = d_fwd(e_q, m_q, w_q, rs_D, tuse_rs);
    assign rt_chk   = d_fwd(e_q, m_q, w_q, rt_D, tuse_rt);
    assign md_stall = md_use_D && (e_q.md_start || (busy_q != 4'd0));

    assign stall  = rs_chk[3] || rt_chk[3] || md_stall;
    assign selRsD = rs_chk[2:0];
    assign selRtD = rt_chk[2:0];
    assign selRsE = e_fwd(m_q, w_q, e_q.rs);
    assign selRtE = e_fwd(m_q, w_q, e_q.rt);
    assign selRtM = hit(w_q, m_q.rt) ? ((w_q.cls == CLS_PC8) ? 3'd1 : 3'd2) : 3'd0;

    always_comb begin
        e_d = '0;
        if (!stall) begin
            e_d.rs       = rs_D;
            e_d.rt       = rt_D;
            e_d.a3       = a3_D;
            e_d.cls      = cls_D;
            e_d.tnew     = tnew_init(cls_D);
            e_d.md_start = md_start_D;
            e_d.md_div   = md_div_D;
        end
        m_d      = e_q;
        m_d.tnew = tnew_dec(e_q.tnew);
        w_d      = m_q;
        w_d.tnew = tnew_dec(m_q.tnew);

        // The MDU counter runs on its own; pipeline stalls do not hold it.
        busy_d = busy_q;
        if (e_q.md_start)           busy_d = e_q.md_div ? DIV_LD : MULT_LD;
        else if (busy_q != 4'd0)    busy_d = busy_q - 4'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            e_q    <= '0;
            m_q    <= '0;
            w_q    <= '0;
            busy_q <= '0;
        end else begin
            e_q    <= e_d;
            m_q    <= m_d;
            w_q    <= w_d;
            busy_q <= busy_d;
        end
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 SHALL have parameter MULT_CYC, default 5, busy cycles of mult/multu after leaving E.
REQ-002 SHALL have parameter DIV_CYC, default 10, busy cycles of div/divu after leaving E.
REQ-003 SHALL have port clk  input  1  sole clock, rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 SHALL have ports rs_D, rt_D  input  5 each  source register numbers of the D-stage instruction.
REQ-006 SHALL have ports tuse_rs, tuse_rt  input  2 each  cycles until operand is needed (0 = D, 1 = E, 2 = M); 3 = operand unused.
REQ-007 SHALL have port a3_D  input  5  destination register of the D instruction; 0 = no write.
REQ-008 SHALL have port cls_D  input  2  result class: 0 ALU, 1 MEM (load), 2 PC8 (link), 3 MD (mfhi/mflo).
REQ-009 SHALL have ports md_start_D, md_div_D, md_use_D  input  1 each  D starts mult/div, start is a divide, D instruction touches HI/LO or the MDU.
REQ-010 SHALL have ports selRsD, selRtD  output  3 each  D forward selects: 0 GRF, 1 pc_E8, 2 pc_M8, 3 aluRet_M, 4 pc_W8, 5 writeData_W, 6 mdOut_E, 7 mdOut_M.
REQ-011 SHALL have ports selRsE, selRtE  output  3 each  E forward selects: 0 stage register, 1 pc_M8, 2 aluRet_M, 3 pc_W8, 4 writeData_W, 5 mdOut_M.
REQ-012 SHALL have port selRtM  output  3  M forward select: 0 rt_M, 1 pc_W8, 2 writeData_W.
REQ-013 SHALL have port stall  output  1  freeze PC and F/D, insert bubble into E.

Function
REQ-014 SHALL keep internal stage records E, M, W, each holding rs, rt, a3, cls, tnew (2 bits), md_start, md_div.
REQ-015 SHALL, on each clock edge, load W<=M and M<=E, and decrement each moved tnew by 1, saturating at 0.
REQ-016 SHALL, on each clock edge, load E from the D inputs when stall=0, or a bubble (all fields 0) when stall=1.
REQ-017 SHALL set tnew at E entry by class: PC8 0, MD 0, ALU 1, MEM 2.
REQ-018 SHALL treat a stage as matching an operand only when stage a3 != 0 and stage a3 == operand register; the nearest stage (E, then M, then W) wins.
REQ-019 SHALL, for each D operand with tuse != 3, stall when the nearest match has tnew > tuse.
REQ-020 SHALL, for a D operand whose nearest match has tnew == 0, select E/PC8->1, E/MD->6, M/PC8->2, M/ALU->3, M/MD->7, W/PC8->4, W/other->5; otherwise 0.
REQ-021 SHALL, for E operands (rs/rt of record E), select M/PC8->1, M/ALU->2, M/MD->5, W/PC8->3, W/other->4; otherwise 0; only M/W matches considered.
REQ-022 SHALL drive selRtM=1 if W matches rt of M with cls PC8, 2 if W matches otherwise, else 0.
REQ-023 SHALL hold a 4-bit busy counter loaded with DIV_CYC or MULT_CYC on the edge where record E has md_start=1, else decremented toward 0 each cycle, independent of stall.
REQ-024 SHALL stall when md_use_D=1 and (E.md_start=1 or counter != 0).
REQ-025 SHALL form stall as the OR of rs, rt and MDU conditions; all outputs purely combinational from records, counter and D inputs.
REQ-026 SHALL give register 0 no forwarding and no stall, regardless of tnew.

Reset
REQ-027 SHALL, while reset=0, clear all records and the counter immediately, giving stall=0 and every sel=0.
REQ-028 SHALL, after reset release, resume normal operation from the first rising edge; an aborted mult/div leaves no residual busy.

Verification
REQ-029 SHALL pass: addu $1 then addu using $1 (tuse_rs=1) -> no stall; next cycle selRsE=2.
REQ-030 SHALL pass: lw $2 then beq $2 (tuse 0) -> stall=1 for 2 cycles, then selRsD=5.
REQ-031 SHALL pass: jal (a3=31, cls PC8) then jr $31 -> stall=0, selRsD=1.
REQ-032 SHALL pass: mult followed by mflo -> stall for 6 cycles (MULT_CYC+1); div version -> 11.
REQ-033 SHALL pass: reset=0 pulse during div busy -> stall=0 at once; mflo after release -> no stall.
REQ-034 SHALL pass: producer with a3=0 followed by consumer of $0 -> all sel=0, stall=0.
